// File: rtl/lsu_64_bit.sv
// lsu_64_bit - load/store unit in front of data_memory_64_bit.
//
// Takes byte-addressed load/store requests (byte/half/word/double) from the
// CPU execute stage and drives the doubleword-indexed memory interface.
// Loads extract the addressed field and sign/zero extend it. Partial stores
// are done as read-modify-write of the containing doubleword.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_write, req_size   store/load select; size 00 b, 01 h, 10 w, 11 d
//   req_unsigned          loads: 1 zero-extend, 0 sign-extend
//   req_addr, req_wdata   byte address and store data (low 8*2^size bits)
//   resp_valid            one-cycle completion pulse
//   resp_rdata            extended load data, held until the next load
//   resp_err              misaligned or out-of-range access (with resp_valid)
//   mem_E, mem_address, mem_write_data, mem_write, mem_read -> memory
//   mem_read_data         <- memory, valid the cycle after a read edge
//
// Build option: define LSU_RANGE_CHECK_EN to reject addresses >= DEPTH*8.
// Without it the upper address bits are ignored and the index wraps.

module lsu_64_bit #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_E,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [63:0] mem_read_data
);

    localparam int          IDXW  = $clog2(DEPTH);
    localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

`ifdef LSU_RANGE_CHECK_EN
    localparam logic RANGE_EN = 1'b1;
`else
    localparam logic RANGE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ERR      = 3'd1,
        LD_ISSUE = 3'd2,
        LD_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        RMW_READ = 3'd5,
        RMW_WAIT = 3'd6
    } state_t;

    state_t      state_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [2:0]  off_q;
    logic [63:0] wdata_q;

    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [63:0] resp_rdata_q;
    logic        mem_e_q;
    logic [63:0] mem_address_q;
    logic [63:0] mem_write_data_q;
    logic        mem_write_q;
    logic        mem_read_q;

    logic        misaligned_s;
    logic        out_of_range_s;
    logic        req_err_s;
    logic [5:0]  shift_s;
    logic [63:0] lane_mask_s;
    logic [63:0] field_s;
    logic [63:0] load_ext_d;
    logic [63:0] merged_d;

    // Alignment check of the incoming request against its size.
    always_comb begin
        misaligned_s = 1'b0;
        case (req_size)
            2'b00:   misaligned_s = 1'b0;
            2'b01:   misaligned_s = req_addr[0];
            2'b10:   misaligned_s = |req_addr[1:0];
            2'b11:   misaligned_s = |req_addr[2:0];
            default: misaligned_s = 1'b0;
        endcase
    end

    // The range compare is always computed; it only matters when enabled.
    assign out_of_range_s = (req_addr >= LIMIT);
    assign req_err_s      = misaligned_s | (RANGE_EN & out_of_range_s);

    assign shift_s = {off_q, 3'b000};
    assign field_s = mem_read_data >> shift_s;

    // Lane mask for the latched access size, right-aligned.
    always_comb begin
        lane_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
        case (size_q)
            2'b00:   lane_mask_s = 64'h0000_0000_0000_00FF;
            2'b01:   lane_mask_s = 64'h0000_0000_0000_FFFF;
            2'b10:   lane_mask_s = 64'h0000_0000_FFFF_FFFF;
            2'b11:   lane_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
            default: lane_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    // Sign or zero extension of the extracted load field.
    always_comb begin
        load_ext_d = field_s;
        case (size_q)
            2'b00: begin
                if (unsigned_q) load_ext_d = {56'd0, field_s[7:0]};
                else            load_ext_d = {{56{field_s[7]}}, field_s[7:0]};
            end
            2'b01: begin
                if (unsigned_q) load_ext_d = {48'd0, field_s[15:0]};
                else            load_ext_d = {{48{field_s[15]}}, field_s[15:0]};
            end
            2'b10: begin
                if (unsigned_q) load_ext_d = {32'd0, field_s[31:0]};
                else            load_ext_d = {{32{field_s[31]}}, field_s[31:0]};
            end
            2'b11:   load_ext_d = field_s;
            default: load_ext_d = field_s;
        endcase
    end

    // Partial store: replace only the addressed lanes of the read doubleword.
    assign merged_d = (mem_read_data & ~(lane_mask_s << shift_s))
                    | ((wdata_q & lane_mask_s) << shift_s);

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            size_q           <= 2'b00;
            unsigned_q       <= 1'b0;
            off_q            <= 3'd0;
            wdata_q          <= 64'd0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= 64'd0;
            mem_e_q          <= 1'b0;
            mem_address_q    <= 64'd0;
            mem_write_data_q <= 64'd0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        size_q        <= req_size;
                        unsigned_q    <= req_unsigned;
                        off_q         <= req_addr[2:0];
                        wdata_q       <= req_wdata;
                        req_ready_q   <= 1'b0;
                        mem_address_q <= {{(64-IDXW){1'b0}}, req_addr[3 +: IDXW]};
                        if (req_err_s) begin
                            state_q <= ERR;
                        end else if (!req_write) begin
                            state_q    <= LD_ISSUE;
                            mem_e_q    <= 1'b1;
                            mem_read_q <= 1'b1;
                        end else if (req_size == 2'b11) begin
                            state_q          <= ST_WRITE;
                            mem_e_q          <= 1'b1;
                            mem_write_q      <= 1'b1;
                            mem_write_data_q <= req_wdata;
                        end else begin
                            state_q    <= RMW_READ;
                            mem_e_q    <= 1'b1;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                LD_ISSUE: begin
                    mem_e_q    <= 1'b0;
                    mem_read_q <= 1'b0;
                    state_q    <= LD_WAIT;
                end
                LD_WAIT: begin
                    resp_rdata_q <= load_ext_d;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                ST_WRITE: begin
                    mem_e_q      <= 1'b0;
                    mem_write_q  <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                RMW_READ: begin
                    mem_e_q    <= 1'b0;
                    mem_read_q <= 1'b0;
                    state_q    <= RMW_WAIT;
                end
                RMW_WAIT: begin
                    mem_e_q          <= 1'b1;
                    mem_write_q      <= 1'b1;
                    mem_read_q       <= 1'b0;
                    mem_write_data_q <= merged_d;
                    state_q          <= ST_WRITE;
                end
                default: begin
                    mem_e_q     <= 1'b0;
                    mem_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_E          = mem_e_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;

endmodule

// File: tb/tb_lsu_64_bit.sv
// Self-checking bench for lsu_64_bit: a behavioural memory sits behind the
// unit, and a byte-level reference model predicts responses and contents.

module tb_lsu_64_bit;

    localparam int DEPTH  = 1024;
    localparam int IW     = $clog2(DEPTH);
    localparam int NBYTES = DEPTH * 8;

`ifdef LSU_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_E;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [63:0] mem_read_data;

    lsu_64_bit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_E          (mem_E),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Deterministic initial memory contents; word 0 holds 53.
    function automatic logic [63:0] init_word(input int i);
        if (i == 0) return 64'd53;
        return {32'(i) * 32'h9E37_79B9, 32'(i) ^ 32'hA5A5_0F0F};
    endfunction

    // Behavioural memory plus protocol monitors.
    logic [63:0] mem [0:DEPTH-1];
    logic        init_mem = 1'b1;
    int          rd_edges = 0;
    int          wr_edges = 0;
    int          e_edges  = 0;
    int          proto_err = 0;
    logic        prev_rv = 1'b0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else begin
            if (mem_E && mem_write) mem[mem_address[IW-1:0]] <= mem_write_data;
            if (mem_E && mem_read)  mem_read_data <= mem[mem_address[IW-1:0]];
        end
        if (mem_E && mem_read)  rd_edges <= rd_edges + 1;
        if (mem_E && mem_write) wr_edges <= wr_edges + 1;
        if (mem_E)              e_edges  <= e_edges + 1;
        if ((mem_read && mem_write) || (resp_valid && prev_rv) || ((mem_address >> IW) != 64'd0))
            proto_err <= proto_err + 1;
        prev_rv <= resp_valid;
    end

    // Reference model: flat byte array and last load result.
    logic [7:0]  ref_mem [0:NBYTES-1];
    logic [63:0] exp_rdata = 64'd0;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_word(input int w);
        logic [63:0] v;
        v = 64'd0;
        for (int b = 0; b < 8; b++) v = v | (64'(ref_mem[w*8+b]) << (8*b));
        return v;
    endfunction

    // One request through the unit, with every outcome predicted from the model.
    task automatic do_op(input string tag, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [63:0] addr, input logic [63:0] wd);
        int nb, ea, lat, exp_lat, exp_rd, exp_wr, rd0, wr0, e0;
        logic err;
        logic [63:0] v;
        nb  = 1 << sz;
        err = (int'(addr[2:0]) % nb) != 0;
        if (RANGE_EN && addr >= 64'(NBYTES)) err = 1'b1;
        ea  = int'(addr % 64'(NBYTES));
        if (err)            begin exp_lat = 1; exp_rd = 0; exp_wr = 0; end
        else if (!wr)       begin exp_lat = 2; exp_rd = 1; exp_wr = 0; end
        else if (nb == 8)   begin exp_lat = 1; exp_rd = 0; exp_wr = 1; end
        else                begin exp_lat = 3; exp_rd = 1; exp_wr = 1; end
        if (!err && !wr) begin
            v = 64'd0;
            for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[ea+i]) << (8*i));
            if (!uns && nb < 8 && v[8*nb-1]) v = v - (64'd1 << (8*nb));
            exp_rdata = v;
        end
        if (!err && wr) begin
            for (int i = 0; i < nb; i++) ref_mem[ea+i] = 8'(wd >> (8*i));
        end
        rd0 = rd_edges; wr0 = wr_edges; e0 = e_edges;

        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        check({tag, "_busy"}, 64'(req_ready), 64'd0);

        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!resp_valid && lat < 10);

        check({tag, "_lat"},   64'(lat),        64'(exp_lat));
        check({tag, "_err"},   64'(resp_err),   64'(err));
        check({tag, "_rdata"}, resp_rdata,      exp_rdata);
        check({tag, "_ready"}, 64'(req_ready),  64'd1);
        check({tag, "_rdedg"}, 64'(rd_edges - rd0), 64'(exp_rd));
        check({tag, "_wredg"}, 64'(wr_edges - wr0), 64'(exp_wr));
        check({tag, "_eedg"},  64'(e_edges - e0),   64'(exp_rd + exp_wr));
        check({tag, "_word"},  mem[ea/8],       ref_word(ea/8));
    endtask

    initial begin
        int rd0, wr0, bad;
        for (int w = 0; w < DEPTH; w++)
            for (int b = 0; b < 8; b++) ref_mem[w*8+b] = 8'(init_word(w) >> (8*b));

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  64'(req_ready),  64'd1);
        check("rst_rvalid", 64'(resp_valid), 64'd0);
        check("rst_rerr",   64'(resp_err),   64'd0);
        check("rst_rdata",  resp_rdata,      64'd0);
        check("rst_ctrl",   {61'd0, mem_E, mem_read, mem_write}, 64'd0);
        check("rst_addr",   mem_address,     64'd0);
        check("rst_wdata",  mem_write_data,  64'd0);
        init_mem = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        do_op("dl0", 1'b0, 2'b11, 1'b0, 64'h0, 64'd0);
        check("dl0_val", resp_rdata, 64'h35);
        do_op("ds10", 1'b1, 2'b11, 1'b0, 64'h10, 64'h8877_6655_4433_2211);
        do_op("lb17s", 1'b0, 2'b00, 1'b0, 64'h17, 64'd0);
        check("lb17s_val", resp_rdata, 64'hFFFF_FFFF_FFFF_FF88);
        do_op("lb17u", 1'b0, 2'b00, 1'b1, 64'h17, 64'd0);
        check("lb17u_val", resp_rdata, 64'h0000_0000_0000_0088);
        do_op("sh12", 1'b1, 2'b01, 1'b0, 64'h12, 64'h1234_5678_9ABC_BEEF);
        check("sh12_val", mem[2], 64'h8877_6655_BEEF_2211);
        do_op("lw06", 1'b0, 2'b10, 1'b0, 64'h6, 64'd0);
        check("lw06_err", 64'(resp_err), 64'd1);
        do_op("dl2000", 1'b0, 2'b11, 1'b0, 64'h2000, 64'd0);
        if (RANGE_EN) check("dl2000_val", 64'(resp_err), 64'd1);
        else          check("dl2000_val", resp_rdata, 64'h35);

        // Reset while a byte store to 0x11 sits in RMW_WAIT.
        rd0 = rd_edges; wr0 = wr_edges;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 64'h11; req_wdata = 64'h5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_rvalid", 64'(resp_valid), 64'd0);
        check("mrst_ready",  64'(req_ready),  64'd1);
        check("mrst_ctrl",   {61'd0, mem_E, mem_read, mem_write}, 64'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid) bad++;
        end
        check("mrst_noresp", 64'(bad), 64'd0);
        check("mrst_rdedg",  64'(rd_edges - rd0), 64'd1);
        check("mrst_wredg",  64'(wr_edges - wr0), 64'd0);
        check("mrst_word2",  mem[2], ref_word(2));
        exp_rdata = 64'd0;
        check("mrst_rdata",  resp_rdata, 64'd0);

        // Randomised traffic, mostly in a small window so loads see stores.
        for (int k = 0; k < 200; k++) begin
            logic [63:0] a;
            logic [1:0]  sz;
            int          r;
            sz = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            r  = int'($urandom_range(0, 7));
            if (r == 1)      a = a & 64'(NBYTES - 1);
            else if (r != 0) a = a & 64'hFF;
            if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
            do_op("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
        end

        check("protocol", 64'(proto_err), 64'd0);
        bad = 0;
        for (int w = 0; w < DEPTH; w++) if (mem[w] !== ref_word(w)) bad++;
        check("mem_final", 64'(bad), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lsu_64_bit.md
Name: lsu_64_bit

Overview:
- Load/store unit sitting directly upstream of `data_memory_64_bit` in the SS_CPU datapath.
- Accepts byte-addressed load/store requests of size byte, half, word or double from the CPU execute stage.
- Drives the memory's doubleword-indexed interface: `E`, `address`, `write_data`, `mem_write` and `mem_read`.
- Performs sub-doubleword extraction and sign/zero extension on loads, and read-modify-write for partial stores.

Parameters:
- DEPTH, 1024, number of 64-bit words in the downstream memory; index width is log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  unit idle, can accept a request
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 double
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0; ignored for stores
- req_addr  in  64  byte address
- req_wdata  in  64  store data; the low 8·2^size bits are used
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  extended load data; holds its value until the next load completes
- resp_err  out  1  qualified by resp_valid; misaligned or out-of-range access
- mem_E  out  1  to memory `E`
- mem_address  out  64  doubleword index: zero-extended req_addr[3+:log2(DEPTH)]
- mem_write_data  out  64  to memory `write_data`
- mem_write  out  1  to memory `mem_write`
- mem_read  out  1  to memory `mem_read`
- mem_read_data  in  64  from memory `read_data`; valid in the cycle after a read edge

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: rst_n is sampled low on a rising clk edge.
  - All outputs are registered.
- Reset values:
  - state=IDLE, req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_E=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
- Reset mid-operation: return to IDLE immediately. An in-flight store whose write edge has not occurred is dropped, and no resp_valid is issued.
- Request acceptance:
  - A request is accepted on edge A where req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - Request fields are latched at A; the CPU may change inputs afterwards.
- Byte offset: off = req_addr[2:0].
- Alignment rule: misaligned when off is not a multiple of 2^size (half: off[0]; word: off[1:0]; double: off[2:0]).
- States: IDLE, ERR, LD_ISSUE, LD_WAIT, ST_WRITE, RMW_READ, RMW_WAIT.
- Transitions from IDLE on accept:
  - Error → ERR.
  - Load → LD_ISSUE.
  - Double store → ST_WRITE.
  - Byte/half/word store → RMW_READ.
- ERR:
  - No memory access.
  - resp_valid=1 and resp_err=1 after edge A+1; returns to IDLE.
  - resp_rdata is unchanged.
- Load path:
  - LD_ISSUE: mem_E=1, mem_read=1. The memory captures on edge A+1 → LD_WAIT with mem_E=0.
  - LD_WAIT: at edge A+2, the field is extracted from mem_read_data at bit 8·off, width 8·2^size.
  - The field is extended per req_unsigned and written to resp_rdata; resp_valid=1 and resp_err=0 for the cycle after A+2; state → IDLE.
  - A double load ignores req_unsigned.
- Double store:
  - ST_WRITE after A: mem_E=1, mem_write=1, mem_write_data=req_wdata.
  - Memory commits on edge A+1.
  - resp_valid pulses after A+1; state → IDLE.
- Partial store:
  - RMW_READ: mem_E=1, mem_read=1; read edge at A+1 → RMW_WAIT.
  - At A+2: merge req_wdata low bits into mem_read_data lanes [8·off +: 8·2^size], leaving other lanes unchanged. Drive mem_write_data=merged, mem_write=1, mem_read=0 → ST_WRITE.
  - Commit at A+3; resp_valid pulses after A+3.
- mem_read and mem_write are never asserted together.
- mem_E is 0 in IDLE and ERR.
- resp_valid is never asserted for two consecutive cycles.
- A new request may be accepted in the same cycle resp_valid=1, because state is already IDLE.

Optional Feature:
- Macro: LSU_RANGE_CHECK_EN.
- Defined: req_addr ≥ DEPTH·8 is an error. It takes the ERR path (resp_err=1) and issues no memory access.
- Undefined: upper address bits are ignored and the index wraps modulo DEPTH. For example, with DEPTH=1024, byte address 0x2000 accesses word 0.
- The misalignment check is always present.

Test Plan:
- Double load, addr 0 (memory word 0 = 53) → resp_valid after A+2, resp_rdata=0x35, resp_err=0, req_ready low for 2 cycles.
- Double store 0x8877665544332211 at addr 0x10, then byte load addr 0x17 with signed and unsigned requests → 0xFFFFFFFFFFFFFF88 and 0x0000000000000088.
- Half store 0xBEEF at addr 0x12 over word 2 = 0x8877665544332211 → word 2 = 0x88776655BEEF2211. A mem_read edge, then a mem_write edge, resp at A+3.
- Word load addr 0x06 → resp_err=1 after A+1, mem_E never asserted, resp_rdata unchanged.
- Address 0x2000 double load: with LSU_RANGE_CHECK_EN → resp_err=1; without → returns word 0 (0x35).
- rst_n low during RMW_WAIT of a byte store to addr 0x11 → no mem_write edge, word 2 unchanged, resp_valid=0, req_ready=1 after the reset edge.
